// File: rtl/ldpc_3gpp_dec_obuffer_source.sv
// Output-buffer reader: streams one bank per block through a 2-stage read pipe into a 4-deep skid FIFO.
// Optional macro LDPC_3GPP_DEC_OBUFFER_SOURCE_TAG_EN stores the bank tag per beat; otherwise otag is 0.
module ldpc_3gpp_dec_obuffer_source #(
    parameter int pADDR_W  = 8,
    parameter int pDAT_W   = 8,
    parameter int pDAT_NUM = 8,
    parameter int pTAG_W   = 4
) (
    input  logic                         iclk,
    input  logic                         ireset,
    input  logic                         iclkena,
    input  logic                         iempty,
    input  logic [pADDR_W:0]             ilen,
    input  logic [pDAT_W*pDAT_NUM-1:0]   irdat,
    input  logic [pTAG_W-1:0]            irtag,
    output logic [pADDR_W-1:0]           oraddr,
    output logic                         orempty,
    input  logic                         iready,
    output logic                         oval,
    output logic                         osop,
    output logic                         oeop,
    output logic [pDAT_W*pDAT_NUM-1:0]   odat,
    output logic [pTAG_W-1:0]            otag,
    output logic                         obusy
);

    // Handshake: a beat transfers on a rising edge where oval, iready and iclkena are all high;
    // odat/osop/oeop/otag stay stable while oval is high and iready is low.

    typedef enum logic [1:0] {IDLE, READ, DONE, GUARD} state_t;

    state_t               state, state_nxt;
    logic [pADDR_W:0]     len_r, cnt, last_addr;
    logic [2:0]           occ, load;
    logic                 issue, last_issue;
    logic                 v1, v2, s1, s2, e1, e2;
    logic                 push, pop;
    logic [1:0]           wptr, rptr;

    logic [pDAT_W*pDAT_NUM-1:0] mem_d [4];
    logic                       mem_s [4];
    logic                       mem_e [4];

    assign last_addr  = len_r - {{pADDR_W{1'b0}}, 1'b1};
    // Credit: FIFO words plus reads still in the pipe must fit in the 4 FIFO slots.
    assign load       = occ + {2'b00, v1} + {2'b00, v2};
    assign issue      = (state == READ) && (load < 3'd4) && iclkena;
    assign last_issue = issue && (cnt == last_addr);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!iempty) state_nxt = READ;
            READ:    if (last_issue) state_nxt = DONE;
            DONE:    state_nxt = GUARD;
            GUARD:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state <= IDLE;
            len_r <= '0;
            cnt   <= '0;
        end else if (iclkena) begin
            state <= state_nxt;
            if (state == IDLE && !iempty) begin
                len_r <= (ilen == '0) ? {{pADDR_W{1'b0}}, 1'b1} : ilen;
                cnt   <= '0;
            end else if (issue) begin
                cnt <= cnt + {{pADDR_W{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            v1 <= 1'b0; s1 <= 1'b0; e1 <= 1'b0;
            v2 <= 1'b0; s2 <= 1'b0; e2 <= 1'b0;
        end else if (iclkena) begin
            v1 <= issue;
            s1 <= issue && (cnt == '0);
            e1 <= last_issue;
            v2 <= v1;
            s2 <= s1;
            e2 <= e1;
        end
    end

    assign push = v2 && iclkena;
    assign pop  = (occ != 3'd0) && iready && iclkena;

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            occ  <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            occ <= occ + {2'b00, push} - {2'b00, pop};
            if (push) wptr <= wptr + 2'd1;
            if (pop)  rptr <= rptr + 2'd1;
        end
    end

    always_ff @(posedge iclk) begin
        if (push) begin
            mem_d[wptr] <= irdat;
            mem_s[wptr] <= s2;
            mem_e[wptr] <= e2;
        end
    end

`ifdef LDPC_3GPP_DEC_OBUFFER_SOURCE_TAG_EN
    logic [pTAG_W-1:0] tag_r, t1, t2;
    logic [pTAG_W-1:0] mem_t [4];

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            tag_r <= '0;
            t1    <= '0;
            t2    <= '0;
        end else if (iclkena) begin
            if (state == IDLE && !iempty) tag_r <= irtag;
            t1 <= tag_r;
            t2 <= t1;
        end
    end

    always_ff @(posedge iclk) begin
        if (push) mem_t[wptr] <= t2;
    end

    assign otag = oval ? mem_t[rptr] : '0;
`else
    logic unused_tag;
    assign unused_tag = ^irtag;
    assign otag       = '0;
`endif

    // Head fields are masked while empty so stale entries never leak out (and reset shows zeros).
    assign oval    = (occ != 3'd0);
    assign odat    = oval ? mem_d[rptr] : '0;
    assign osop    = oval && mem_s[rptr];
    assign oeop    = oval && mem_e[rptr];
    assign oraddr  = cnt[pADDR_W-1:0];
    assign orempty = (state == DONE) && iclkena;
    assign obusy   = (state != IDLE);

endmodule

// File: doc/ldpc_3gpp_dec_obuffer_source.md
LDPC_3GPP_DEC_OBUFFER_SOURCE -- requirements
Module: ldpc_3gpp_dec_obuffer_source

Interface
REQ-001 SHALL have parameter pADDR_W, default 8, word address width of one buffer bank.
REQ-002 SHALL have parameter pDAT_W, default 8, width of one data lane.
REQ-003 SHALL have parameter pDAT_NUM, default 8, number of data lanes.
REQ-004 SHALL have parameter pTAG_W, default 4, block tag width.
REQ-005 SHALL have port iclk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port ireset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port iclkena  in  1  clock enable; low freezes all state.
REQ-008 SHALL have port iempty  in  1  buffer empty flag; low means a full bank is ready to read.
REQ-009 SHALL have port ilen  in  pADDR_W+1  words per block; legal range 1..2^pADDR_W.
REQ-010 SHALL have port irdat  in  pDAT_W x pDAT_NUM  buffer read data; read latency is 2 ticks.
REQ-011 SHALL have port irtag  in  pTAG_W  tag of the bank currently being read.
REQ-012 SHALL have port oraddr  out  pADDR_W  buffer read address.
REQ-013 SHALL have port orempty  out  1  single-cycle bank release strobe.
REQ-014 SHALL have port iready  in  1  downstream ready.
REQ-015 SHALL have port oval, osop, oeop  out  1 each  output beat valid, first word, last word.
REQ-016 SHALL have port odat  out  pDAT_W x pDAT_NUM  output data.
REQ-017 SHALL have port otag  out  pTAG_W  tag of the current output beat.
REQ-018 SHALL have port obusy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-019 FSM SHALL have states IDLE, READ, DONE and GUARD.
REQ-020 IDLE SHALL, when iempty=0, capture ilen and irtag and move to READ with the address counter at 0; ilen=0 SHALL be treated as 1.
REQ-021 READ SHALL issue one read per cycle, driving oraddr=counter and incrementing it, only while (FIFO occupancy + reads in flight) < 4.
REQ-022 READ SHALL move to DONE in the cycle after address len-1 is issued.
REQ-023 DONE SHALL assert orempty for exactly one cycle, then move to GUARD.
REQ-024 GUARD SHALL ignore iempty for one cycle, then return to IDLE.
REQ-025 A 2-stage issue pipeline SHALL carry valid, sop (addr 0), eop (addr len-1) and tag alongside each read; it SHALL write irdat into a 4-entry output FIFO in issue cycle +2.
REQ-026 oval SHALL equal FIFO non-empty; odat, osop, oeop and otag SHALL come from the FIFO head; the head SHALL pop when oval and iready are both high.
REQ-027 The FIFO SHALL never overflow or underflow; words SHALL be neither lost nor duplicated under any iready pattern.
REQ-028 With iready held high, the first oval SHALL occur 3 cycles after the first read issue, and throughput SHALL be 1 word/cycle within a block.
REQ-029 Consecutive blocks SHALL each be bracketed by exactly one osop and one oeop; ilen=1 SHALL give osop=oeop=1 on the same beat.
REQ-030 iclkena=0 SHALL freeze the FSM, counter, pipeline and FIFO; orempty SHALL be 0 while frozen.

Reset
REQ-031 ireset low SHALL asynchronously force IDLE, counter=0, pipeline cleared, FIFO empty.
REQ-032 During reset: oval=osop=oeop=orempty=obusy=0, oraddr=0, odat=0, otag=0.
REQ-033 Reset asserted mid-block SHALL abort the block without issuing orempty.

Configuration
REQ-034 Macro LDPC_3GPP_DEC_OBUFFER_SOURCE_TAG_EN defined: the tag SHALL be stored per FIFO entry, and otag SHALL follow the head beat.
REQ-035 Macro undefined: no tag storage SHALL exist, otag SHALL be constant 0, and irtag SHALL be unused.

Verification
REQ-036 pADDR_W=3, ilen=8, iready=1, ram word k=k -> 8 beats 0..7, osop on 0, oeop on 7, one orempty pulse the cycle after addr 7 is issued.
REQ-037 ilen=8, iready alternating 1/0 -> data 0..7 in order with no loss or duplication, FIFO occupancy never >4, oraddr stalls when credit is exhausted.
REQ-038 Two blocks back to back, tags 0x3 then 0xA (TAG_EN defined) -> otag=0x3 through first oeop, otag=0xA from second osop; one orempty per block.
REQ-039 ilen=1 -> single beat with osop=oeop=1, orempty pulsed once.
REQ-040 ireset low at beat 4 of ilen=8 -> all outputs 0 immediately, no orempty; after release, FSM in IDLE and a new block streams correctly.
REQ-041 iclkena=0 for 5 cycles mid-block -> outputs and oraddr hold their values; the stream resumes intact.
